// File: rtl/razor_arb_pkg.sv
// Shared types and helpers for the Razor adder arbiter.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package razor_arb_pkg;

  // Arbiter operating mode: NORMAL allows full pipelining, SAFE allows a
  // single operation in flight while the adder recovers from a timing error.
  typedef enum logic {
    NORMAL = 1'b0,
    SAFE   = 1'b1
  } arb_state_e;

  localparam int ERRCNT_W = 16;

  // Width needed to index n items; never less than 1 so a 2-entry
  // structure still gets a real bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/razor_tag_fifo.sv
// Small synchronous FIFO holding the owner tag of each in-flight adder op.
// Latency: head is combinational from storage; a push is visible at head one cycle later.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports:
//   clk, rst_n          clock and async active-low reset (clears pointers and count)
//   push, push_dat      write one entry
//   pop                 drop the head entry
//   head                oldest entry (undefined when empty)
//   count, full, empty  occupancy
module razor_tag_fifo
  import razor_arb_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign do_pop = pop && !empty;
  // When full, a same-cycle pop frees the slot being written: the write
  // lands on the head entry only after it has been consumed this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read when count says they
  // were written since the last reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/razor_adder_arbiter.sv
// Round-robin arbiter sharing one Razor-protected 8-bit adder among NUM_REQ requesters.
// Latency: 0 cycles on issue (grant is combinational) and 0 cycles on return (results pass through).
// Backpressure: issue stalls when the tag FIFO is full or in SAFE mode with an op in flight; add_out_rdy follows rsp_rdy of the owning requester.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_vld/req_rdy/req_a/req_b/req_cin  per-requester issue side (8-bit lanes packed by index)
//   rsp_vld/rsp_rdy/rsp_sum/rsp_cout     per-requester return side (sum/cout broadcast)
//   add_*                            issue/return interface of the shared adder pipeline
//   safe_mode                        registered, high while throttled after a mismatch
//   err_clr, err_cnt                 only with RAZOR_ARB_ERRCNT_EN: saturating mismatch counter
//
// Build option: define RAZOR_ARB_ERRCNT_EN to add the err_clr/err_cnt mismatch counter.
module razor_adder_arbiter
  import razor_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int SAFE_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_vld,
  output logic [NUM_REQ-1:0]   req_rdy,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  output logic [NUM_REQ-1:0]   rsp_vld,
  input  logic [NUM_REQ-1:0]   rsp_rdy,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_cout,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  output logic                 add_in_vld,
  input  logic                 add_in_rdy,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout,
  input  logic                 add_out_vld,
  output logic                 add_out_rdy,
  input  logic                 add_mismatch,
  output logic                 safe_mode
`ifdef RAZOR_ARB_ERRCNT_EN
  ,
  input  logic                 err_clr,
  output logic [ERRCNT_W-1:0]  err_cnt
`endif
);

  localparam int TAG_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_INFLIGHT) + 1;
  localparam int SCNT_W = 8;
  localparam logic [SCNT_W-1:0] SAFE_LOAD = SCNT_W'(SAFE_CYCLES);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [SCNT_W-1:0] safe_cnt;
  logic [SCNT_W-1:0] safe_cnt_nxt;

  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  gnt_idx;
  logic              gnt_found;
  logic              gnt_vld;
  int                scan_idx;

  logic              allow;
  logic              issue_hs;
  logic              result_hs;
  logic              mis_hs;

  logic [TAG_W-1:0]  head_tag;
  logic [CNT_W-1:0]  inflight;
  logic              fifo_full;
  logic              fifo_empty;

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------

  // rst_n is folded in so nothing is offered to the adder while in reset,
  // even though count==0/NORMAL would otherwise make issue eligible.
  assign allow = rst_n
              && (inflight < CNT_W'(MAX_INFLIGHT))
              && ((state == NORMAL) || fifo_empty);

  // First requesting index at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_vld[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAG_W'(scan_idx);
      end
    end
  end

  assign gnt_vld    = allow && gnt_found;
  assign add_in_vld = gnt_vld;
  assign issue_hs   = gnt_vld && add_in_rdy;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    req_rdy = '0;
    if (gnt_vld) begin
      add_a   = req_a[8*int'(gnt_idx) +: 8];
      add_b   = req_b[8*int'(gnt_idx) +: 8];
      add_cin = req_cin[gnt_idx];
      req_rdy[gnt_idx] = add_in_rdy;
    end
  end

  // The pointer only moves on an accepted issue, so a stalled requester
  // keeps its priority until the adder takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue_hs) begin
      rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner tracking
  // ---------------------------------------------------------------------------

  razor_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_hs),
    .push_dat (gnt_idx),
    .pop      (result_hs),
    .head     (head_tag),
    .count    (inflight),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Return side
  // ---------------------------------------------------------------------------

  // A result with nothing in flight has no owner: it is neither routed nor
  // accepted, which leaves the adder stuck until reset (and trips the check below).
  always_comb begin
    rsp_vld = '0;
    if (add_out_vld && !fifo_empty) begin
      rsp_vld[head_tag] = 1'b1;
    end
  end

  assign add_out_rdy = !fifo_empty && rsp_rdy[head_tag];
  assign rsp_sum     = rst_n ? add_sum  : 8'h00;
  assign rsp_cout    = rst_n && add_cout;

  assign result_hs = add_out_vld && add_out_rdy;
  assign mis_hs    = result_hs && add_mismatch;

  // ---------------------------------------------------------------------------
  // NORMAL / SAFE mode
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      safe_cnt <= '0;
    end else begin
      state    <= state_nxt;
      safe_cnt <= safe_cnt_nxt;
    end
  end

  // In SAFE, a fresh mismatch restarts the hold; leaving requires both the
  // hold to have expired and the pipeline to have drained.
  always_comb begin
    state_nxt    = state;
    safe_cnt_nxt = safe_cnt;
    case (state)
      NORMAL: begin
        if (mis_hs) begin
          state_nxt    = SAFE;
          safe_cnt_nxt = SAFE_LOAD;
        end
      end
      SAFE: begin
        if (mis_hs) begin
          safe_cnt_nxt = SAFE_LOAD;
        end else if (safe_cnt != '0) begin
          safe_cnt_nxt = safe_cnt - 1'b1;
        end else if (fifo_empty) begin
          state_nxt = NORMAL;
        end
      end
      default: begin
        state_nxt    = NORMAL;
        safe_cnt_nxt = '0;
      end
    endcase
  end

  assign safe_mode = (state == SAFE);

  // ---------------------------------------------------------------------------
  // Optional mismatch counter
  // ---------------------------------------------------------------------------

`ifdef RAZOR_ARB_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (mis_hs && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------

  a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n)
    !(add_out_vld && fifo_empty));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_hs && fifo_full && !result_hs));

  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    inflight <= CNT_W'(MAX_INFLIGHT));

endmodule

// File: tb/tb_razor_adder_arbiter.sv
// Randomized bench for razor_adder_arbiter with an in-bench adder and requester model.
// Latency: n/a.
// Backpressure: random add_in_rdy / rsp_rdy phases exercise both stall paths.
module tb_razor_adder_arbiter;

  localparam int N    = 4;
  localparam int MAXI = 4;
  localparam int SC   = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_rdy;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   rsp_vld;
  logic [N-1:0]   rsp_rdy;
  logic [7:0]     rsp_sum;
  logic           rsp_cout;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic           add_cin;
  logic           add_in_vld;
  logic           add_in_rdy;
  logic [7:0]     add_sum;
  logic           add_cout;
  logic           add_out_vld;
  logic           add_out_rdy;
  logic           add_mismatch;
  logic           safe_mode;
`ifdef RAZOR_ARB_ERRCNT_EN
  logic           err_clr;
  logic [15:0]    err_cnt;
`endif

  razor_adder_arbiter #(
    .NUM_REQ      (N),
    .MAX_INFLIGHT (MAXI),
    .SAFE_CYCLES  (SC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_in_vld   (add_in_vld),
    .add_in_rdy   (add_in_rdy),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .add_out_vld  (add_out_vld),
    .add_out_rdy  (add_out_rdy),
    .add_mismatch (add_mismatch),
    .safe_mode    (safe_mode)
`ifdef RAZOR_ARB_ERRCNT_EN
    ,
    .err_clr      (err_clr),
    .err_cnt      (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight operation as the adder sees it.
  typedef struct {
    int         owner;
    logic [8:0] res;
    int         due;
    bit         mis;
  } op_t;

  op_t        inflight[$];
  bit [N-1:0] rq_v;
  logic [7:0] rq_a [N];
  logic [7:0] rq_b [N];
  bit         rq_c [N];
  int         rr;
  bit         safe;
  int         scnt;
  int         errc;
  int         cyc;

  // Stimulus knobs (percentages and latency range).
  int p_req, p_in_rdy, p_rsp_rdy, p_mis, lat_min, lat_max;

  int n_chk, n_pass, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of stimulus, checking and reference-model update.
  task automatic step();
    int         cnt;
    int         g;
    int         idx;
    bit         allow, exp_in_vld, issue, pop, mis, ovld, eordy;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [7:0] ea, eb;
    bit         ec;
    op_t        op;

    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rq_v[i] && ($urandom_range(99) < p_req)) begin
        rq_v[i] = 1'b1;
        rq_a[i] = 8'($urandom);
        rq_b[i] = 8'($urandom);
        rq_c[i] = 1'($urandom);
      end
      req_vld[i]       = rq_v[i];
      req_a[8*i +: 8]  = rq_a[i];
      req_b[8*i +: 8]  = rq_b[i];
      req_cin[i]       = rq_c[i];
      rsp_rdy[i]       = ($urandom_range(99) < p_rsp_rdy);
    end
    add_in_rdy = ($urandom_range(99) < p_in_rdy);
`ifdef RAZOR_ARB_ERRCNT_EN
    err_clr = ($urandom_range(99) < 3);
`endif

    cnt  = inflight.size();
    ovld = (cnt > 0) && (inflight[0].due <= cyc);
    add_out_vld = ovld;
    if (ovld) {add_cout, add_sum} = inflight[0].res;
    else      {add_cout, add_sum} = 9'($urandom);
    add_mismatch = ovld ? inflight[0].mis : 1'($urandom);
    #1;

    // Expected combinational behaviour from the arbitration rules.
    allow = (cnt < MAXI) && (!safe || cnt == 0);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (g < 0 && rq_v[idx]) g = idx;
    end
    exp_in_vld = allow && (g >= 0);
    ea = 8'h00; eb = 8'h00; ec = 1'b0; exp_rdy = '0;
    if (exp_in_vld) begin
      ea = rq_a[g]; eb = rq_b[g]; ec = rq_c[g];
      exp_rdy[g] = add_in_rdy;
    end
    exp_rv = '0; eordy = 1'b0;
    if (cnt > 0) begin
      eordy = rsp_rdy[inflight[0].owner];
      if (ovld) exp_rv[inflight[0].owner] = 1'b1;
    end

    check("add_in_vld",  32'(add_in_vld),  32'(exp_in_vld));
    check("req_rdy",     32'(req_rdy),     32'(exp_rdy));
    check("add_a",       32'(add_a),       32'(ea));
    check("add_b",       32'(add_b),       32'(eb));
    check("add_cin",     32'(add_cin),     32'(ec));
    check("rsp_vld",     32'(rsp_vld),     32'(exp_rv));
    check("add_out_rdy", 32'(add_out_rdy), 32'(eordy));
    if (ovld) begin
      check("rsp_sum",  32'(rsp_sum),  32'(inflight[0].res[7:0]));
      check("rsp_cout", 32'(rsp_cout), 32'(inflight[0].res[8]));
    end
    check("safe_mode",   32'(safe_mode),   32'(safe));
`ifdef RAZOR_ARB_ERRCNT_EN
    check("err_cnt",     32'(err_cnt),     32'(errc));
`endif

    // Advance the reference model across the coming clock edge.
    issue = exp_in_vld && add_in_rdy;
    pop   = ovld && eordy;
    mis   = pop && inflight[0].mis;

    if (!safe) begin
      if (mis) begin safe = 1'b1; scnt = SC; end
    end else if (mis) begin
      scnt = SC;
    end else if (scnt > 0) begin
      scnt = scnt - 1;
    end else if (cnt == 0) begin
      safe = 1'b0;
    end

`ifdef RAZOR_ARB_ERRCNT_EN
    if (err_clr) errc = 0;
    else if (mis && errc < 65535) errc = errc + 1;
`endif

    if (pop) void'(inflight.pop_front());
    if (issue) begin
      op.owner = g;
      op.res   = 9'(rq_a[g]) + 9'(rq_b[g]) + 9'(rq_c[g]);
      op.due   = cyc + $urandom_range(lat_max, lat_min);
      op.mis   = ($urandom_range(99) < p_mis);
      inflight.push_back(op);
      rr = (g + 1) % N;
      rq_v[g] = 1'b0;
    end
    cyc++;
  endtask

  // Assert reset with every input active, check that all outputs are
  // forced low, then release with the inputs quiet.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n        = 1'b0;
    req_vld      = '1;
    req_a        = '1;
    req_b        = '1;
    req_cin      = '1;
    add_in_rdy   = 1'b1;
    rsp_rdy      = '1;
    add_out_vld  = 1'b1;
    add_sum      = 8'h5A;
    add_cout     = 1'b1;
    add_mismatch = 1'b1;
`ifdef RAZOR_ARB_ERRCNT_EN
    err_clr      = 1'b0;
`endif
    #1;
    check({tag, "_add_in_vld"},  32'(add_in_vld),  32'd0);
    check({tag, "_req_rdy"},     32'(req_rdy),     32'd0);
    check({tag, "_add_a"},       32'(add_a),       32'd0);
    check({tag, "_rsp_vld"},     32'(rsp_vld),     32'd0);
    check({tag, "_add_out_rdy"}, 32'(add_out_rdy), 32'd0);
    check({tag, "_rsp_sum"},     32'(rsp_sum),     32'd0);
    check({tag, "_rsp_cout"},    32'(rsp_cout),    32'd0);
    check({tag, "_safe_mode"},   32'(safe_mode),   32'd0);
`ifdef RAZOR_ARB_ERRCNT_EN
    check({tag, "_err_cnt"},     32'(err_cnt),     32'd0);
`endif
    inflight.delete();
    rr = 0; safe = 1'b0; scnt = 0; errc = 0;
    @(negedge clk);
    req_vld      = '0;
    add_in_rdy   = 1'b0;
    add_out_vld  = 1'b0;
    add_mismatch = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic set_knobs(input int pr, input int pi, input int ps, input int pm,
                           input int lmin, input int lmax);
    p_req = pr; p_in_rdy = pi; p_rsp_rdy = ps; p_mis = pm; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
    rq_v = '0;
    for (int i = 0; i < N; i++) begin rq_a[i] = 8'h00; rq_b[i] = 8'h00; rq_c[i] = 1'b0; end
    rst_n = 1'b0;
    req_vld = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_rdy = '0;
    add_in_rdy = 1'b0; add_sum = '0; add_cout = 1'b0; add_out_vld = 1'b0; add_mismatch = 1'b0;
`ifdef RAZOR_ARB_ERRCNT_EN
    err_clr = 1'b0;
`endif
    apply_reset("por");

    // Fairness: everyone requesting, adder always ready, 2-cycle results.
    // Requester 0 opens with FF+01+0 so the carry-out path is exercised.
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b1; rq_a[i] = 8'(17 * i + 3); rq_b[i] = 8'(5 * i); rq_c[i] = 1'(i);
    end
    rq_a[0] = 8'hFF; rq_b[0] = 8'h01; rq_c[0] = 1'b0;
    set_knobs(100, 100, 100, 0, 2, 2);
    for (int t = 0; t < 40; t++) step();

    // Full stall: long adder latency fills all tag slots.
    set_knobs(100, 100, 100, 0, 8, 8);
    for (int t = 0; t < 60; t++) step();

    // Mismatches with random handshakes: SAFE entry, drain and reload.
    set_knobs(70, 80, 80, 15, 1, 3);
    for (int t = 0; t < 400; t++) step();

    // Heavy response backpressure.
    set_knobs(90, 90, 20, 5, 1, 4);
    for (int t = 0; t < 250; t++) step();

    // Reset while operations are in flight.
    set_knobs(100, 100, 0, 0, 6, 6);
    for (int t = 0; t < 40 && inflight.size() < 2; t++) step();
    apply_reset("midrst");

    // Post-reset: all requesting again so arbitration restarts at index 0.
    set_knobs(100, 100, 100, 0, 2, 2);
    for (int t = 0; t < 20; t++) step();

    // Mixed random traffic.
    set_knobs(60, 75, 70, 8, 1, 5);
    for (int t = 0; t < 600; t++) step();

    // Quiet drain so SAFE mode can expire.
    set_knobs(0, 100, 100, 0, 1, 2);
    for (int t = 0; t < 60; t++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
